// File: rtl/traffic_pkg.sv
// traffic_pkg: shared segment patterns, scan select defaults and decoder FSM encoding
package traffic_pkg;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [2:0] SEL_ONES_DEF = 3'd5;
  localparam logic [2:0] SEL_TENS_DEF = 3'd4;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD = 4'hE;
  localparam logic [1:0] ST_WAIT_ONES = 2'd0;
  localparam logic [1:0] ST_WAIT_TENS = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational inverse 7-segment decode with invalid-pattern flag
module seg7_to_bcd import traffic_pkg::*; (
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       invalid
);
  assign bcd = seg == SEG_0 ? 4'd0 : seg == SEG_1 ? 4'd1 : seg == SEG_2 ? 4'd2 :
               seg == SEG_3 ? 4'd3 : seg == SEG_4 ? 4'd4 : seg == SEG_5 ? 4'd5 :
               seg == SEG_6 ? 4'd6 : seg == SEG_7 ? 4'd7 : seg == SEG_8 ? 4'd8 :
               seg == SEG_9 ? 4'd9 : seg == SEG_BLANK ? BCD_BLANK : BCD_BAD;
  assign invalid = bcd == BCD_BAD;
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: scan-bus receiver assembling a 2-digit value; SEG7_DEDUP_EN suppresses repeated frames
module seg7_scan_decoder import traffic_pkg::*; #(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT_CYC = 65536,
  parameter logic [2:0] SEL_ONES = SEL_ONES_DEF,
  parameter logic [2:0] SEL_TENS = SEL_TENS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg7_in,
  input  logic [2:0] seg7_sel_in,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [6:0] value_bin,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       timeout
);
  localparam int RW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [9:0] s1, s2, p;
  logic [RW-1:0] run;
  logic [TW-1:0] tcnt;
  logic [1:0] state;
  logic [3:0] ones_st, bcd, t_eff, o_eff;
  logic [6:0] value_nxt;
  logic bad, eq, acc, is_ones, is_tens, fresh;
  seg7_to_bcd u_dec (.seg(s2[6:0]), .bcd(bcd), .invalid(bad));
  assign eq = s2 == p;
  assign acc = eq && run == RW'(STABLE_CYC - 1);
  assign is_ones = acc && s2[9:7] == SEL_ONES;
  assign is_tens = acc && s2[9:7] == SEL_TENS;
  assign t_eff = bcd == BCD_BLANK ? 4'd0 : bcd;
  assign o_eff = ones_st == BCD_BLANK ? 4'd0 : ones_st;
  assign value_nxt = {t_eff, 3'b000} + {2'b00, t_eff, 1'b0} + {3'b000, o_eff};
`ifdef SEG7_DEDUP_EN
  logic emitted;
  assign fresh = !emitted || {bcd, ones_st} != {digit_tens, digit_ones};
  always_ff @(posedge clk)
    if (rst) emitted <= 1'b0;
    else if (frame_valid) emitted <= 1'b1;
`else
  assign fresh = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, p} <= '0;
      run <= '0;
      tcnt <= '0;
      state <= ST_WAIT_ONES;
      ones_st <= '0;
      {digit_tens, digit_ones, value_bin} <= '0;
      {frame_valid, seg_err, timeout} <= '0;
    end else begin
      s1 <= {seg7_sel_in, seg7_in};
      s2 <= s1;
      p <= s2;
      run <= !eq ? '0 : run == RW'(STABLE_CYC) ? run : run + 1'b1;
      tcnt <= tcnt + 1'b1;
      {frame_valid, seg_err, timeout} <= '0;
      // a malformed digit poisons the whole frame, whichever half it belongs to
      if ((is_ones || is_tens) && bad && state != ST_EMIT) begin
        seg_err <= 1'b1;
        state <= ST_WAIT_ONES;
      end else begin
        case (state)
          ST_WAIT_ONES: if (is_ones) begin
            ones_st <= bcd;
            tcnt <= '0;
            state <= ST_WAIT_TENS;
          end
          ST_WAIT_TENS: if (is_tens) begin
            state <= ST_EMIT;
            if (fresh) begin
              digit_tens <= bcd;
              digit_ones <= ones_st;
              value_bin <= value_nxt;
              frame_valid <= 1'b1;
            end
          end else if (is_ones) begin
            ones_st <= bcd;
            tcnt <= '0;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            state <= ST_WAIT_ONES;
          end
          default: state <= ST_WAIT_ONES;
        endcase
      end
    end
  end
endmodule
